psram_xfer_engine: RTL and testbench
====================================

Name: psram_xfer_engine

Overview:
Parametrised successor of the team's PSRAM transfer core. It issues one octal-DDR PSRAM transaction per accepted request: command, address, latency, then a data burst.
- Burst width, address width and SCK divider range are generic; the divider is any even ratio, not a fixed set of four.
- Read data is captured on DQS edges, with a timeout and error report.
- Sits between the bus-side PSRAM controller and the pad ring.

Parameters:
DATA_BYTES, 8, bytes per burst; even, 2..64
ADDR_WIDTH, 32, address width; multiple of 8, 8..32
DIV_WIDTH, 8, width of the SCK half-period divider
TOUT_WIDTH, 8, width of the read DQS-timeout counter

Ports:
clk_i  in  1  core clock; all logic on its rising edge
rst_n_i  in  1  reset, synchronous, active-low
cfg_div_i  in  DIV_WIDTH  SCK half-period in clk_i cycles; 0 treated as 1
cfg_tcsp_i  in  4  CE-fall to first SCK edge, clk_i cycles
cfg_tchd_i  in  4  last SCK edge to CE-rise, clk_i cycles
cfg_recy_i  in  8  CE-high recovery, clk_i cycles
cfg_rcmd_i / cfg_wcmd_i  in  8 each  read / write command byte
cfg_rlc_i / cfg_wlc_i  in  6 each  read / write latency, full SCK periods
cfg_tout_i  in  TOUT_WIDTH  max clk_i cycles between DQS edges in RDATA
xfer_valid_i  in  1  request
xfer_ready_o  out  1  engine idle, request accepted when valid&ready
xfer_rdwr_i  in  1  1 = read, 0 = write
xfer_addr_i  in  ADDR_WIDTH  byte address
xfer_wdata_i  in  8*DATA_BYTES  write burst, byte 0 in bits [7:0], sent first
xfer_wmask_i  in  DATA_BYTES  1 = byte written
xfer_rdata_o  out  8*DATA_BYTES  read burst, byte 0 in [7:0]
xfer_done_o  out  1  one-cycle completion pulse
xfer_err_o  out  1  valid with done; 1 = read timeout
psram_sck_o  out  1  PSRAM clock
psram_ce_o  out  1  chip enable, active-low
psram_io_en_o  out  1  1 = drive DQ
psram_io_out_o  out  8  DQ out
psram_io_in_i  in  8  DQ in
psram_dqs_en_o  out  1  1 = drive DQS/DM
psram_dqs_out_o  out  1  DM out, 1 = byte masked
psram_dqs_in_i  in  1  DQS in, asynchronous

Behaviour:
- Reset, and any cycle with rst_n_i=0 even mid-transfer, gives:
  - state IDLE, ce=1, sck=0, io_en=0, dqs_en=0;
  - io_out=0, dqs_out=0, done=0, err=0, rdata=0.
  - No partial completion pulse is produced.
- Handshake:
  - xfer_ready_o=1 only in IDLE.
  - On valid&ready, the engine latches rdwr, addr, wdata, wmask, all cfg_* values and the selected cmd/lc.
  - Inputs and cfg are don't-care after acceptance.
- States: IDLE→TCSP→INST→ADDR→LATN→(WDATA|RDATA)→TCHD→RECY→IDLE.
- Half-period tick: a counter reloads to max(cfg_div,1)-1 and fires when it reaches 0. It runs only in INST..DATA and restarts on TCSP exit.
- SCK toggles on each tick and is 0 outside INST..DATA. Each phase has an even half-period count, so SCK ends low.
- ce=0 from TCSP through TCHD inclusive.
- TCSP: lasts tcsp+1 cycles, outputs the cmd byte, io_en=1.
- INST: 2 half-periods; the cmd byte is held on both edges.
- ADDR: ADDR_WIDTH/8 half-periods, one address byte per half-period, MSB byte first. ADDR_WIDTH/8 odd ⇒ pad one 0x00 byte first.
- LATN: 2*lc half-periods.
  - Write: io_en=1, io_out=0, dqs_en=1, dqs_out=0.
  - Read: io_en=0, dqs_en=0.
  - lc=0 ⇒ zero-length LATN.
- WDATA: DATA_BYTES half-periods. Byte i is on io_out and dqs_out=~wmask[i] for half-period i; dqs_en=1.
- RDATA: io_en=0, dqs_en=0. DQS capture:
  - DQS goes through a 2-flop synchroniser followed by an edge detector (either edge).
  - On each detected edge, the current psram_io_in_i is stored at byte index k, then k increments.
  - At k==DATA_BYTES: go to TCHD, err=0.
  - Timeout counter: reset to 0 on entry and on each edge, otherwise increments. Reaching cfg_tout_i (0 ⇒ never) goes to TCHD with err=1; uncaptured bytes keep their previous values.
  - SCK keeps toggling during RDATA, stopping low at the next even half-period boundary on exit.
- TCHD: tchd+1 cycles. RECY: recy+1 cycles with ce=1.
- xfer_done_o pulses in the first RECY cycle. xfer_rdata_o is stable from that pulse until the next read's done; writes leave it unchanged.

Test Plan:
- Write: div=1, tcsp=tchd=recy=0, wcmd=0xA0, addr=0x00001234, wlc=2, wdata=0x0807060504030201, wmask=0xFF. Required DQ sequence: A0,A0,00,00,12,34, 4×00, then 01..08 with DM=0; ce low for exactly the transfer; one done, err=0.
- Masked write: wmask=0xA5 ⇒ DM per byte = 0,1,0,1,1,0,1,0.
- Read: div=3, rlc=5. Model drives DQS toggles 4 cycles apart with bytes 0x11..0x88 ⇒ rdata=0x8877665544332211, err=0; SCK half-period = 3 clk_i cycles.
- Timeout: model stops after 3 DQS edges, cfg_tout=20 ⇒ done with err=1, bytes 0..2 updated, ce rises after tchd.
- Back-to-back: valid held high ⇒ second request accepted only after recy+1 CE-high cycles; ready=0 throughout.
- Reset asserted mid-ADDR ⇒ next cycle ce=1, sck=0, ready=1, no done pulse.

Source files
------------

// File: rtl/psram_xfer_engine.sv
// psram_xfer_engine: one octal-DDR PSRAM command/address/latency/burst transaction per request
module psram_xfer_engine #(
  parameter int DATA_BYTES = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DIV_WIDTH  = 8,
  parameter int TOUT_WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [DIV_WIDTH-1:0]    cfg_div_i,
  input  logic [3:0]              cfg_tcsp_i,
  input  logic [3:0]              cfg_tchd_i,
  input  logic [7:0]              cfg_recy_i,
  input  logic [7:0]              cfg_rcmd_i,
  input  logic [7:0]              cfg_wcmd_i,
  input  logic [5:0]              cfg_rlc_i,
  input  logic [5:0]              cfg_wlc_i,
  input  logic [TOUT_WIDTH-1:0]   cfg_tout_i,
  input  logic                    xfer_valid_i,
  output logic                    xfer_ready_o,
  input  logic                    xfer_rdwr_i,
  input  logic [ADDR_WIDTH-1:0]   xfer_addr_i,
  input  logic [8*DATA_BYTES-1:0] xfer_wdata_i,
  input  logic [DATA_BYTES-1:0]   xfer_wmask_i,
  output logic [8*DATA_BYTES-1:0] xfer_rdata_o,
  output logic                    xfer_done_o,
  output logic                    xfer_err_o,
  output logic                    psram_sck_o,
  output logic                    psram_ce_o,
  output logic                    psram_io_en_o,
  output logic [7:0]              psram_io_out_o,
  input  logic [7:0]              psram_io_in_i,
  output logic                    psram_dqs_en_o,
  output logic                    psram_dqs_out_o,
  input  logic                    psram_dqs_in_i
);
  localparam int AB = ADDR_WIDTH/8 + (ADDR_WIDTH/8)%2;
  localparam int KW = $clog2(DATA_BYTES+1);
  typedef enum logic [3:0] {IDLE, TCSP, INST, ADDR, LATN, WDATA, RDATA, TCHD, RECY} state_t;
  state_t state, state_nx, data_st;
  logic rdwr_q, rd_fin, terr, run, tick, hp_end, cnt_done, dqs_edge, fin_go;
  logic [8*AB-1:0] asr;
  logic [8*DATA_BYTES-1:0] wsr, rbuf;
  logic [DATA_BYTES-1:0] msr;
  logic [DIV_WIDTH-1:0] divm1, div_cnt;
  logic [3:0] tcsp_q, tchd_q;
  logic [7:0] recy_q, cmd_q, cnt, hp_cnt, hp_last;
  logic [5:0] lc_q;
  logic [TOUT_WIDTH-1:0] tout_q, tcnt;
  logic [KW-1:0] k;
  logic [2:0] dqs_sync;
  assign data_st = rdwr_q ? RDATA : WDATA;
  assign run = state inside {INST, ADDR, LATN, WDATA, RDATA};
  assign tick = run && div_cnt == '0;
  assign hp_last = state == INST ? 8'd1 : state == ADDR ? 8'(AB-1) :
                   state == LATN ? {1'b0, lc_q, 1'b0} - 8'd1 : 8'(DATA_BYTES-1);
  assign hp_end = tick && hp_cnt == hp_last;
  assign cnt_done = cnt == (state == TCSP ? {4'b0, tcsp_q} : state == TCHD ? {4'b0, tchd_q} : recy_q);
  assign dqs_edge = dqs_sync[1] ^ dqs_sync[2];
  assign fin_go = state == TCHD && cnt_done;
  assign xfer_ready_o = state == IDLE;
  assign psram_ce_o = state == IDLE || state == RECY;
  assign psram_io_en_o = state inside {TCSP, INST, ADDR, WDATA} || (state == LATN && !rdwr_q);
  assign psram_io_out_o = state inside {TCSP, INST} ? cmd_q : state == ADDR ? asr[8*AB-1 -: 8] :
                          state == WDATA ? wsr[7:0] : 8'h00;
  assign psram_dqs_en_o = state == WDATA || (state == LATN && !rdwr_q);
  assign psram_dqs_out_o = state == WDATA && !msr[0];
  always_ff @(posedge clk_i) state <= !rst_n_i ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = xfer_valid_i ? TCSP : IDLE;
      TCSP:    state_nx = cnt_done ? INST : TCSP;
      INST:    state_nx = hp_end ? ADDR : INST;
      ADDR:    state_nx = !hp_end ? ADDR : lc_q == '0 ? data_st : LATN;
      LATN:    state_nx = hp_end ? data_st : LATN;
      WDATA:   state_nx = hp_end ? TCHD : WDATA;
      RDATA:   state_nx = rd_fin && tick && psram_sck_o ? TCHD : RDATA;
      TCHD:    state_nx = cnt_done ? RECY : TCHD;
      RECY:    state_nx = cnt_done ? IDLE : RECY;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      {rdwr_q, rd_fin, terr, psram_sck_o, xfer_done_o, xfer_err_o} <= '0;
      {asr, wsr, rbuf, msr, divm1, div_cnt, xfer_rdata_o} <= '0;
      {tcsp_q, tchd_q, recy_q, cmd_q, cnt, hp_cnt, lc_q, tout_q, tcnt, k, dqs_sync} <= '0;
    end else begin
      dqs_sync <= {dqs_sync[1:0], psram_dqs_in_i};
      cnt <= state_nx != state ? 8'd0 : cnt + 8'd1;
      div_cnt <= run && !tick ? div_cnt - DIV_WIDTH'(1) : divm1;
      hp_cnt <= !run || hp_end ? 8'd0 : hp_cnt + {7'b0, tick};
      psram_sck_o <= run && (psram_sck_o ^ tick);
      if (state == IDLE && xfer_valid_i) begin
        rdwr_q <= xfer_rdwr_i;
        asr <= (8*AB)'(xfer_addr_i);
        wsr <= xfer_wdata_i;
        msr <= xfer_wmask_i;
        divm1 <= cfg_div_i == '0 ? '0 : cfg_div_i - DIV_WIDTH'(1);
        tcsp_q <= cfg_tcsp_i;
        tchd_q <= cfg_tchd_i;
        recy_q <= cfg_recy_i;
        cmd_q <= xfer_rdwr_i ? cfg_rcmd_i : cfg_wcmd_i;
        lc_q <= xfer_rdwr_i ? cfg_rlc_i : cfg_wlc_i;
        tout_q <= cfg_tout_i;
        rbuf <= xfer_rdata_o;
        {rd_fin, terr, k, tcnt} <= '0;
      end
      if (state == ADDR && tick) asr <= asr << 8;
      if (state == WDATA && tick) begin
        wsr <= wsr >> 8;
        msr <= msr >> 1;
      end
      if (state == RDATA && !rd_fin) begin
        if (dqs_edge) begin
          for (int b = 0; b < DATA_BYTES; b++)
            if (k == KW'(b)) rbuf[8*b +: 8] <= psram_io_in_i;
          k <= k + KW'(1);
          tcnt <= '0;
          rd_fin <= k == KW'(DATA_BYTES-1);
        end else if (tout_q != '0 && tcnt == tout_q) begin
          rd_fin <= 1'b1;
          terr <= 1'b1;
        end else tcnt <= tcnt + TOUT_WIDTH'(1);
      end
      xfer_done_o <= fin_go;
      xfer_err_o <= fin_go && terr;
      if (fin_go && rdwr_q) xfer_rdata_o <= rbuf;
    end
  end
endmodule

// File: tb/tb_psram_xfer_engine.sv
// tb_psram_xfer_engine: scoreboard bench for the PSRAM transfer engine
module tb_psram_xfer_engine;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic [7:0] cfg_div, cfg_recy, cfg_rcmd, cfg_wcmd, cfg_tout;
  logic [3:0] cfg_tcsp, cfg_tchd;
  logic [5:0] cfg_rlc, cfg_wlc;
  logic xfer_valid, xfer_ready, xfer_rdwr, xfer_done, xfer_err;
  logic [31:0] xfer_addr;
  logic [63:0] xfer_wdata, xfer_rdata;
  logic [7:0] xfer_wmask, io_out, io_in;
  logic sck, ce, io_en, dqs_en, dqs_out, dqs_in;
  typedef struct packed {logic err; logic [63:0] rdata;} done_t;
  logic [10:0] q_dq[$];
  done_t q_done[$];
  int n_chk = 0, n_bad = 0, done_cnt = 0, last_low = 0, last_high = 0, hp_min = 0, hp_max = 0, busy_ready = 0;
  int m_low = 0, m_high = 0, m_since = 0;
  bit m_have = 0;
  logic m_sck = 0, m_ce = 1;
  logic [10:0] m_rec = '0;
  logic [63:0] model_rdata = '0;
  done_t m_d;

  psram_xfer_engine dut (
    .clk_i(clk), .rst_n_i(rst_n), .cfg_div_i(cfg_div), .cfg_tcsp_i(cfg_tcsp), .cfg_tchd_i(cfg_tchd),
    .cfg_recy_i(cfg_recy), .cfg_rcmd_i(cfg_rcmd), .cfg_wcmd_i(cfg_wcmd), .cfg_rlc_i(cfg_rlc),
    .cfg_wlc_i(cfg_wlc), .cfg_tout_i(cfg_tout), .xfer_valid_i(xfer_valid), .xfer_ready_o(xfer_ready),
    .xfer_rdwr_i(xfer_rdwr), .xfer_addr_i(xfer_addr), .xfer_wdata_i(xfer_wdata), .xfer_wmask_i(xfer_wmask),
    .xfer_rdata_o(xfer_rdata), .xfer_done_o(xfer_done), .xfer_err_o(xfer_err), .psram_sck_o(sck),
    .psram_ce_o(ce), .psram_io_en_o(io_en), .psram_io_out_o(io_out), .psram_io_in_i(io_in),
    .psram_dqs_en_o(dqs_en), .psram_dqs_out_o(dqs_out), .psram_dqs_in_i(dqs_in)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // each SCK toggle closes a half-period; its DQ/DM record is popped against the scoreboard
  initial forever begin
    @(negedge clk);
    m_since++;
    if (sck !== m_sck) begin
      if (q_dq.size() > 0) chk("dq", 64'(m_rec), 64'(q_dq.pop_front()));
      if (m_have) begin
        hp_min = m_since < hp_min ? m_since : hp_min;
        hp_max = m_since > hp_max ? m_since : hp_max;
      end
      m_have = 1;
      m_since = 0;
    end
    if (!ce && m_ce) begin
      last_high = m_high;
      m_high = 0;
      m_have = 0;
      hp_min = 1000;
      hp_max = 0;
    end
    if (ce && !m_ce) begin
      last_low = m_low;
      m_low = 0;
    end
    if (ce) m_high++; else m_low++;
    if (!ce && xfer_ready) busy_ready++;
    if (xfer_done) begin
      chk("done_ce", 64'({m_ce, ce}), 64'(2'b01));
      if (q_done.size() == 0) chk("done_unexp", 64'(xfer_done), 64'(0));
      else begin
        m_d = q_done.pop_front();
        chk("err", 64'(xfer_err), 64'(m_d.err));
        chk("rdata", xfer_rdata, m_d.rdata);
      end
      done_cnt++;
    end
    m_sck = sck;
    m_ce = ce;
    m_rec = {io_en, dqs_en, dqs_out, io_out};
  end

  task automatic push_dq(input bit rd, input logic [7:0] cmd, input logic [31:0] a, input int lc,
                         input logic [63:0] wd, input logic [7:0] wm);
    repeat (2) q_dq.push_back({3'b100, cmd});
    for (int i = 3; i >= 0; i--) q_dq.push_back({3'b100, a[8*i +: 8]});
    repeat (2*lc) q_dq.push_back(rd ? 11'h000 : 11'h600);
    if (!rd) for (int i = 0; i < 8; i++) q_dq.push_back({2'b11, ~wm[i], wd[8*i +: 8]});
  endtask

  task automatic send();
    int c = 0;
    xfer_valid = 1;
    while (!xfer_ready && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("accept_tmo", 64'(c < 200), 64'(1));
    @(negedge clk);
  endtask

  task automatic wait_done(input int n);
    int c = 0;
    while (done_cnt < n && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk("done_tmo", 64'(done_cnt >= n), 64'(1));
  endtask

  task automatic wait_tog(input int n);
    int c = 0, t = 0;
    logic p = sck;
    while (t < n && c < 3000) begin
      @(negedge clk);
      c++;
      if (sck !== p) t++;
      p = sck;
    end
    chk("tog_tmo", 64'(c < 3000), 64'(1));
  endtask

  task automatic xfer(input bit rd, input logic [31:0] a, input logic [63:0] wd, input logic [7:0] wm,
                      input logic [63:0] rb, input int ndqs, input bit e);
    int lc = rd ? int'(cfg_rlc) : int'(cfg_wlc);
    int dv = cfg_div == 0 ? 1 : int'(cfg_div);
    int start = done_cnt;
    push_dq(rd, rd ? cfg_rcmd : cfg_wcmd, a, lc, wd, wm);
    if (rd) for (int i = 0; i < ndqs; i++) model_rdata[8*i +: 8] = rb[8*i +: 8];
    q_done.push_back('{err: e, rdata: model_rdata});
    xfer_rdwr = rd;
    xfer_addr = a;
    xfer_wdata = wd;
    xfer_wmask = wm;
    send();
    xfer_valid = 0;
    xfer_rdwr = ~rd;
    xfer_addr = $urandom;
    xfer_wdata = {$urandom, $urandom};
    xfer_wmask = 8'($urandom);
    if (rd) begin
      wait_tog(6 + 2*lc);
      for (int i = 0; i < ndqs; i++) begin
        io_in = rb[8*i +: 8];
        dqs_in = ~dqs_in;
        repeat (4) @(negedge clk);
      end
    end
    wait_done(start + 1);
    chk("dq_left", 64'(q_dq.size()), 64'(0));
    if (!rd) chk("ce_low", 64'(last_low), 64'(cfg_tcsp + 1 + dv*(6 + 2*lc + 8) + cfg_tchd + 1));
    else begin
      chk("hp_min", 64'(hp_min), 64'(dv));
      chk("hp_max", 64'(hp_max), 64'(dv));
    end
  endtask

  initial begin
    int start;
    cfg_div = 1; cfg_tcsp = 0; cfg_tchd = 0; cfg_recy = 0; cfg_rcmd = 8'h20; cfg_wcmd = 8'hA0;
    cfg_rlc = 5; cfg_wlc = 2; cfg_tout = 0;
    xfer_valid = 0; xfer_rdwr = 0; xfer_addr = 0; xfer_wdata = 0; xfer_wmask = 0; io_in = 0; dqs_in = 0;
    repeat (3) @(negedge clk);
    chk("rst_ce", 64'(ce), 64'(1));
    chk("rst_sck", 64'(sck), 64'(0));
    chk("rst_io", 64'({io_en, dqs_en, dqs_out, io_out}), 64'(0));
    chk("rst_done", 64'({xfer_done, xfer_err}), 64'(0));
    chk("rst_rdata", xfer_rdata, 64'(0));
    chk("rst_ready", 64'(xfer_ready), 64'(1));
    rst_n = 1;
    @(negedge clk);
    xfer(0, 32'h0000_1234, 64'h0807060504030201, 8'hFF, 0, 0, 0);
    xfer(0, 32'h0000_1234, 64'h0807060504030201, 8'hA5, 0, 0, 0);
    cfg_div = 0; cfg_wlc = 0; cfg_tcsp = 2; cfg_tchd = 1;
    xfer(0, 32'hDEAD_BEEF, 64'h1122334455667788, 8'h3C, 0, 0, 0);
    cfg_div = 3; cfg_tcsp = 0; cfg_tchd = 0;
    xfer(1, 32'h00AB_CDEF, 0, 0, 64'h8877665544332211, 8, 0);
    cfg_tout = 20; cfg_tchd = 2;
    xfer(1, 32'h0000_0040, 0, 0, 64'h0000000000C3B2A1, 3, 1);
    dqs_in = 0;
    cfg_tout = 0; cfg_tchd = 0; cfg_div = 1; cfg_recy = 3; cfg_wlc = 1;
    start = done_cnt;
    push_dq(0, cfg_wcmd, 32'h0102_0304, 1, 64'hA1A2A3A4A5A6A7A8, 8'hF0);
    q_done.push_back('{err: 1'b0, rdata: model_rdata});
    push_dq(0, cfg_wcmd, 32'h0506_0708, 1, 64'hB1B2B3B4B5B6B7B8, 8'h0F);
    q_done.push_back('{err: 1'b0, rdata: model_rdata});
    xfer_rdwr = 0; xfer_addr = 32'h0102_0304; xfer_wdata = 64'hA1A2A3A4A5A6A7A8; xfer_wmask = 8'hF0;
    send();
    xfer_addr = 32'h0506_0708; xfer_wdata = 64'hB1B2B3B4B5B6B7B8; xfer_wmask = 8'h0F;
    send();
    xfer_valid = 0;
    wait_done(start + 2);
    chk("b2b_gap", 64'(last_high), 64'(cfg_recy + 2));
    chk("b2b_dq_left", 64'(q_dq.size()), 64'(0));
    cfg_div = 2; cfg_recy = 0;
    start = done_cnt;
    xfer_rdwr = 0; xfer_addr = 32'h1111_2222;
    send();
    xfer_valid = 0;
    wait_tog(3);
    rst_n = 0;
    @(negedge clk);
    chk("mid_rst_ce", 64'(ce), 64'(1));
    chk("mid_rst_sck", 64'(sck), 64'(0));
    chk("mid_rst_ready", 64'(xfer_ready), 64'(1));
    chk("mid_rst_io", 64'({io_en, dqs_en, xfer_done}), 64'(0));
    rst_n = 1;
    model_rdata = 0;
    repeat (40) @(negedge clk);
    chk("mid_rst_no_done", 64'(done_cnt), 64'(start));
    chk("mid_rst_idle_ce", 64'(ce), 64'(1));
    cfg_div = 1;
    xfer(0, 32'h0000_00FF, 64'h0F0E0D0C0B0A0908, 8'h81, 0, 0, 0);
    chk("ready_busy", 64'(busy_ready), 64'(0));
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
